ucsbece154b_bpred_gshare: RTL and testbench

//  Parametrised fetch-stage branch predictor: tagged BTB + gshare PHT of saturating counters, speculative GHR with

---
 rtl/ucsbece154b_bpred_gshare_pkg.sv | 21 ++
 rtl/ucsbece154b_ras.sv | 82 ++++++++
 rtl/ucsbece154b_bpred_gshare.sv | 183 ++++++++++++++++++
 tb/tb_ucsbece154b_bpred_gshare.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154b_bpred_gshare_pkg.sv
// Shared definitions for the gshare branch predictor: control-flow type encoding,
// PHT counter reset helper and architectural widths.
package ucsbece154b_bpred_gshare_pkg;

    localparam int unsigned ADDR_BITS  = 32;
    localparam int unsigned INSTR_SIZE = 4;

    // Resolved / predicted control-flow class, as carried on upd_type_i.
    typedef enum logic [1:0] {
        BR_BRANCH = 2'b00,
        BR_JUMP   = 2'b01,
        BR_CALL   = 2'b10,
        BR_RETURN = 2'b11
    } brType_e;

    // Weakly-not-taken value for an n-bit saturating counter (0..01..1 below the MSB).
    function automatic int unsigned ctrResetValue(input int unsigned ctrBits);
        return (32'd1 << (ctrBits - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/ucsbece154b_ras.sv
// Return-address stack with checkpoint restore.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   push, pop         push pushAddr / pop top (push wins if both)
//   restore           reload {nonEmpty,ptr} from restorePtr before push/pop apply
//   restorePtr        checkpoint {count-nonzero, ptr}
//   pushAddr          return address to push
//   top               current top-of-stack entry
//   nonEmpty          count != 0
//   checkpoint        {nonEmpty, ptr} for the instruction being fetched
module ucsbece154b_ras
    import ucsbece154b_bpred_gshare_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned RP = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 restore,
    input  logic [RP:0]          restorePtr,
    input  logic [ADDR_BITS-1:0] pushAddr,
    output logic [ADDR_BITS-1:0] top,
    output logic                 nonEmpty,
    output logic [RP:0]          checkpoint
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [ADDR_BITS-1:0] entries [DEPTH];
    logic [RP-1:0]        ptrQ, ptrD, basePtr;
    logic [CW-1:0]        cntQ, cntD, baseCnt;
    logic                 wrEn;

    // Restore first, then apply push/pop on top of the restored pointer.
    // The checkpoint keeps only "non-empty", so a restored stack trusts its top entry alone.
    always_comb begin
        basePtr = ptrQ;
        baseCnt = cntQ;
        if (restore) begin
            basePtr = restorePtr[RP-1:0];
            baseCnt = restorePtr[RP] ? CW'(1) : '0;
        end
        ptrD = basePtr;
        cntD = baseCnt;
        wrEn = 1'b0;
        if (push) begin
            wrEn = 1'b1;
            ptrD = basePtr + RP'(1);
            if (baseCnt != CW'(DEPTH)) begin
                cntD = baseCnt + CW'(1);
            end
        end else if (pop && (baseCnt != '0)) begin
            ptrD = basePtr - RP'(1);
            cntD = baseCnt - CW'(1);
        end
    end

    // Pointer/count state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptrQ <= '0;
            cntQ <= '0;
        end else begin
            ptrQ <= ptrD;
            cntQ <= cntD;
        end
    end

    // Stack storage; a full push overwrites the oldest slot circularly.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            entries[basePtr] <= pushAddr;
        end
    end

    assign top        = entries[ptrQ - RP'(1)];
    assign nonEmpty   = (cntQ != '0);
    assign checkpoint = {nonEmpty, ptrQ};

endmodule

// File: rtl/ucsbece154b_bpred_gshare.sv
// Fetch-stage branch predictor: tagged direct-mapped BTB, gshare PHT of saturating
// counters, speculative GHR with checkpoint restore, and a return-address stack.
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   pc_i, lookup_i, stall_f_i        fetch PC, lookup valid, fetch stall
//   pred_taken_o, pred_target_o      same-cycle prediction
//   pred_ghr_o, pred_rasptr_o        pre-lookup checkpoints travelling with the instruction
//   upd_*                            execute-stage resolution, training and recovery
module ucsbece154b_bpred_gshare
    import ucsbece154b_bpred_gshare_pkg::*;
#(
    parameter int unsigned NUM_BTB_ENTRIES = 32,
    parameter int unsigned NUM_GHR_BITS    = 5,
    parameter int unsigned TAG_BITS        = 8,
    parameter int unsigned CTR_BITS        = 2,
    parameter int unsigned RAS_DEPTH       = 4,
    localparam int unsigned RP = $clog2(RAS_DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [31:0]             pc_i,
    input  logic                    lookup_i,
    input  logic                    stall_f_i,
    output logic                    pred_taken_o,
    output logic [31:0]             pred_target_o,
    output logic [NUM_GHR_BITS-1:0] pred_ghr_o,
    output logic [RP:0]             pred_rasptr_o,
    input  logic                    upd_valid_i,
    input  logic [31:0]             upd_pc_i,
    input  logic [1:0]              upd_type_i,
    input  logic                    upd_taken_i,
    input  logic [31:0]             upd_target_i,
    input  logic [NUM_GHR_BITS-1:0] upd_ghr_i,
    input  logic [RP:0]             upd_rasptr_i,
    input  logic                    upd_mispredict_i
);

    localparam int unsigned IDX       = $clog2(NUM_BTB_ENTRIES);
    localparam int unsigned PHT_DEPTH = 2 ** NUM_GHR_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctrResetValue(CTR_BITS));

    // BTB and PHT storage
    logic                    btbValid  [NUM_BTB_ENTRIES];
    logic [TAG_BITS-1:0]     btbTag    [NUM_BTB_ENTRIES];
    logic [31:0]             btbTarget [NUM_BTB_ENTRIES];
    brType_e                 btbType   [NUM_BTB_ENTRIES];
    logic [CTR_BITS-1:0]     pht       [PHT_DEPTH];
    logic [NUM_GHR_BITS-1:0] ghr, ghrNext;

    // Lookup side
    logic [IDX-1:0]          lookupIdx;
    logic [TAG_BITS-1:0]     lookupTag;
    logic [NUM_GHR_BITS-1:0] lookupPhtIdx;
    brType_e                 lookupType;
    logic                    lookupHit, dirTaken, predTaken;
    logic [31:0]             fallThrough, hitTarget;

    // Update side
    brType_e                 updType;
    logic [IDX-1:0]          updIdx;
    logic [TAG_BITS-1:0]     updTag;
    logic [NUM_GHR_BITS-1:0] trainIdx;
    logic [CTR_BITS-1:0]     trainCur, trainNext;
    logic                    mispredict, specUpdate, btbWrite, phtTrain;

    // RAS interface
    logic                    rasPush, rasPop, rasNonEmpty;
    logic [31:0]             rasPushAddr, rasTop;
    logic [RP:0]             rasCheckpoint;

    // Combinational prediction from current (pre-edge) state.
    always_comb begin
        lookupIdx    = pc_i[IDX+1:2];
        lookupTag    = pc_i[IDX+TAG_BITS+1:IDX+2];
        lookupPhtIdx = pc_i[NUM_GHR_BITS+1:2] ^ ghr;
        lookupType   = btbType[lookupIdx];
        lookupHit    = btbValid[lookupIdx] && (btbTag[lookupIdx] == lookupTag);
        dirTaken     = (lookupType == BR_BRANCH) ? pht[lookupPhtIdx][CTR_BITS-1] : 1'b1;
        predTaken    = lookupHit && dirTaken;
        fallThrough  = pc_i + 32'(INSTR_SIZE);
        hitTarget    = ((lookupType == BR_RETURN) && rasNonEmpty) ? rasTop : btbTarget[lookupIdx];
    end

    assign pred_taken_o  = predTaken;
    assign pred_target_o = predTaken ? hitTarget : fallThrough;
    assign pred_ghr_o    = ghr;
    assign pred_rasptr_o = rasCheckpoint;

    // Update decode; a mispredict overrides any same-cycle speculative lookup.
    always_comb begin
        updType    = brType_e'(upd_type_i);
        updIdx     = upd_pc_i[IDX+1:2];
        updTag     = upd_pc_i[IDX+TAG_BITS+1:IDX+2];
        trainIdx   = upd_pc_i[NUM_GHR_BITS+1:2] ^ upd_ghr_i;
        mispredict = upd_valid_i && upd_mispredict_i;
        specUpdate = lookup_i && !stall_f_i && !upd_mispredict_i && lookupHit;
        btbWrite   = upd_valid_i && (upd_taken_i || (updType != BR_BRANCH));
        phtTrain   = upd_valid_i && (updType == BR_BRANCH);
    end

    // Saturating counter step for the trained PHT entry.
    always_comb begin
        trainCur  = pht[trainIdx];
        trainNext = trainCur;
        if (upd_taken_i && (trainCur != '1)) begin
            trainNext = trainCur + CTR_BITS'(1);
        end else if (!upd_taken_i && (trainCur != '0)) begin
            trainNext = trainCur - CTR_BITS'(1);
        end
    end

    // GHR next state: checkpoint repair on mispredict, else shift in the prediction.
    always_comb begin
        ghrNext = ghr;
        if (mispredict) begin
            ghrNext = (updType == BR_BRANCH) ? {upd_ghr_i[NUM_GHR_BITS-2:0], upd_taken_i}
                                             : upd_ghr_i;
        end else if (specUpdate && (lookupType == BR_BRANCH)) begin
            ghrNext = {ghr[NUM_GHR_BITS-2:0], predTaken};
        end
    end

    // RAS control: recovery replays the resolved call/return after restoring the pointer.
    always_comb begin
        rasPush     = 1'b0;
        rasPop      = 1'b0;
        rasPushAddr = fallThrough;
        if (mispredict) begin
            rasPush     = (updType == BR_CALL);
            rasPop      = (updType == BR_RETURN);
            rasPushAddr = upd_pc_i + 32'(INSTR_SIZE);
        end else if (specUpdate) begin
            rasPush = (lookupType == BR_CALL);
            rasPop  = (lookupType == BR_RETURN);
        end
    end

    // GHR, BTB valid bits and PHT counters: cleared by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghr <= '0;
            for (int unsigned i = 0; i < NUM_BTB_ENTRIES; i++) begin
                btbValid[i] <= 1'b0;
            end
            for (int unsigned i = 0; i < PHT_DEPTH; i++) begin
                pht[i] <= CTR_INIT;
            end
        end else begin
            ghr <= ghrNext;
            if (btbWrite) begin
                btbValid[updIdx] <= 1'b1;
            end
            if (phtTrain) begin
                pht[trainIdx] <= trainNext;
            end
        end
    end

    // BTB payload; qualified by btbValid so it needs no reset.
    always_ff @(posedge clk) begin
        if (btbWrite) begin
            btbTag[updIdx]    <= updTag;
            btbTarget[updIdx] <= upd_target_i;
            btbType[updIdx]   <= updType;
        end
    end

    ucsbece154b_ras #(
        .DEPTH (RAS_DEPTH)
    ) ras (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (rasPush),
        .pop        (rasPop),
        .restore    (mispredict),
        .restorePtr (upd_rasptr_i),
        .pushAddr   (rasPushAddr),
        .top        (rasTop),
        .nonEmpty   (rasNonEmpty),
        .checkpoint (rasCheckpoint)
    );

endmodule

// File: tb/tb_ucsbece154b_bpred_gshare.sv
// Directed bench for the gshare predictor: reset, PHT training/saturation, GHR
// speculation and repair, RAS push/pop/overflow/restore, and async reset.
module tb_ucsbece154b_bpred_gshare;
    import ucsbece154b_bpred_gshare_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc_i;
    logic        lookup_i, stall_f_i;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic [4:0]  pred_ghr_o;
    logic [2:0]  pred_rasptr_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic [1:0]  upd_type_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic [4:0]  upd_ghr_i;
    logic [2:0]  upd_rasptr_i;
    logic        upd_mispredict_i;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ucsbece154b_bpred_gshare dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .pc_i             (pc_i),
        .lookup_i         (lookup_i),
        .stall_f_i        (stall_f_i),
        .pred_taken_o     (pred_taken_o),
        .pred_target_o    (pred_target_o),
        .pred_ghr_o       (pred_ghr_o),
        .pred_rasptr_o    (pred_rasptr_o),
        .upd_valid_i      (upd_valid_i),
        .upd_pc_i         (upd_pc_i),
        .upd_type_i       (upd_type_i),
        .upd_taken_i      (upd_taken_i),
        .upd_target_i     (upd_target_i),
        .upd_ghr_i        (upd_ghr_i),
        .upd_rasptr_i     (upd_rasptr_i),
        .upd_mispredict_i (upd_mispredict_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_upd(input logic v, input logic [1:0] t, input logic [31:0] pc,
                             input logic tk, input logic [31:0] tgt, input logic [4:0] g,
                             input logic [2:0] rp, input logic mp);
        upd_valid_i      = v;
        upd_type_i       = t;
        upd_pc_i         = pc;
        upd_taken_i      = tk;
        upd_target_i     = tgt;
        upd_ghr_i        = g;
        upd_rasptr_i     = rp;
        upd_mispredict_i = mp;
    endtask

    task automatic idle();
        drive_upd(1'b0, BR_BRANCH, 32'h0, 1'b0, 32'h0, 5'h0, 3'h0, 1'b0);
        lookup_i  = 1'b0;
        stall_f_i = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        pc_i    = 32'h100;
        idle();

        // 1: reset state
        #2;
        chk("rst_taken",  32'(pred_taken_o), 32'd0);
        chk("rst_target", pred_target_o, 32'h104);
        chk("rst_ghr",    32'(pred_ghr_o), 32'd0);
        chk("rst_rasptr", 32'(pred_rasptr_o), 32'd0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // 2: train BRANCH 0x200 -> 0x180 (PHT idx 0)
        pc_i = 32'h200;
        drive_upd(1'b1, BR_BRANCH, 32'h200, 1'b1, 32'h180, 5'h0, 3'h0, 1'b0);
        #1;
        chk("same_cycle_old_taken",  32'(pred_taken_o), 32'd0);
        chk("same_cycle_old_target", pred_target_o, 32'h204);
        step();                                       // ctr 01 -> 10
        chk("br_ctr10_taken",  32'(pred_taken_o), 32'd1);
        chk("br_ctr10_target", pred_target_o, 32'h180);
        step();                                       // 10 -> 11
        step();                                       // saturates at 11
        upd_taken_i = 1'b0;
        step();                                       // 11 -> 10
        chk("br_nt_still_taken", 32'(pred_taken_o), 32'd1);
        step();                                       // 10 -> 01
        chk("br_sat_nt_taken",  32'(pred_taken_o), 32'd0);
        chk("br_sat_nt_target", pred_target_o, 32'h204);
        upd_taken_i = 1'b1;
        step();                                       // 01 -> 10
        idle();
        #1;
        chk("br_retaken", 32'(pred_taken_o), 32'd1);
        chk("br_ghr0",    32'(pred_ghr_o), 32'd0);

        // 4: mispredict beats same-cycle lookup shift
        pc_i     = 32'h200;
        lookup_i = 1'b1;
        drive_upd(1'b1, BR_BRANCH, 32'h244, 1'b0, 32'h0, 5'h16, 3'h0, 1'b1);
        #1;
        chk("mp_lookup_taken", 32'(pred_taken_o), 32'd1);
        step();
        idle();
        #1;
        chk("mp_ghr_repair", 32'(pred_ghr_o), 32'h0C);

        // lookup hit, PHT idx 12 still weakly-not-taken: shift in 0
        lookup_i = 1'b1;
        #1;
        chk("ghr0c_pred_taken",  32'(pred_taken_o), 32'd0);
        chk("ghr0c_pred_target", pred_target_o, 32'h204);
        step();
        lookup_i = 1'b0;
        #1;
        chk("ghr_shift0", 32'(pred_ghr_o), 32'h18);
        lookup_i  = 1'b1;
        stall_f_i = 1'b1;
        step();
        idle();
        #1;
        chk("ghr_stall_hold", 32'(pred_ghr_o), 32'h18);

        // JUMP mispredict restores GHR verbatim and allocates BTB
        drive_upd(1'b1, BR_JUMP, 32'h504, 1'b1, 32'h600, 5'h00, 3'h0, 1'b1);
        step();
        idle();
        #1;
        chk("jump_ghr_restore", 32'(pred_ghr_o), 32'h00);
        pc_i     = 32'h200;
        lookup_i = 1'b1;
        step();
        lookup_i = 1'b0;
        #1;
        chk("ghr_shift1", 32'(pred_ghr_o), 32'h01);
        pc_i = 32'h504;
        #1;
        chk("jump_taken",  32'(pred_taken_o), 32'd1);
        chk("jump_target", pred_target_o, 32'h600);

        // 3: CALL 0x300 -> 0x400, RETURN 0x410 (BTB target 0x7F0)
        drive_upd(1'b1, BR_CALL, 32'h300, 1'b1, 32'h400, 5'h0, 3'h0, 1'b0);
        step();
        drive_upd(1'b1, BR_RETURN, 32'h410, 1'b1, 32'h7F0, 5'h0, 3'h0, 1'b0);
        step();
        idle();
        pc_i     = 32'h300;
        lookup_i = 1'b1;
        #1;
        chk("call_target", pred_target_o, 32'h400);
        chk("call_rasptr_pre", 32'(pred_rasptr_o), 32'h0);
        step();
        chk("call_rasptr_post", 32'(pred_rasptr_o), 32'h5);
        pc_i = 32'h410;
        #1;
        chk("ret_taken",  32'(pred_taken_o), 32'd1);
        chk("ret_ras_target", pred_target_o, 32'h304);
        step();
        lookup_i = 1'b0;
        #1;
        chk("ret_rasptr_post", 32'(pred_rasptr_o), 32'h0);
        chk("ret_empty_btb", pred_target_o, 32'h7F0);
        chk("ghr_after_calls", 32'(pred_ghr_o), 32'h01);

        // 5: five CALLs into a 4-deep RAS, then five RETURNs
        for (int i = 0; i < 5; i++) begin
            drive_upd(1'b1, BR_CALL, 32'h320 + 32'(4 * i), 1'b1, 32'h900, 5'h0, 3'h0, 1'b0);
            step();
        end
        idle();
        for (int i = 0; i < 5; i++) begin
            pc_i     = 32'h320 + 32'(4 * i);
            lookup_i = 1'b1;
            step();
        end
        lookup_i = 1'b0;
        #1;
        chk("ras_full_ptr", 32'(pred_rasptr_o), 32'h5);
        for (int i = 0; i < 5; i++) begin
            pc_i     = 32'h410;
            lookup_i = 1'b1;
            #1;
            chk($sformatf("ras_pop%0d", i), pred_target_o,
                (i < 4) ? (32'h334 - 32'(4 * i)) : 32'h7F0);
            step();
        end
        lookup_i = 1'b0;
        #1;
        chk("ras_empty_ptr", 32'(pred_rasptr_o), 32'h1);

        // CALL mispredict: restore {0,10}, re-push 0x704; GHR takes upd_ghr_i
        drive_upd(1'b1, BR_CALL, 32'h700, 1'b1, 32'hA00, 5'h03, 3'b010, 1'b1);
        step();
        idle();
        pc_i = 32'h410;
        #1;
        chk("ras_restore_ptr", 32'(pred_rasptr_o), 32'h7);
        chk("ras_restore_ghr", 32'(pred_ghr_o), 32'h03);
        chk("ras_restore_target", pred_target_o, 32'h704);

        // 6: asynchronous reset in the middle of an update
        drive_upd(1'b1, BR_BRANCH, 32'h200, 1'b1, 32'h180, 5'h0, 3'h0, 1'b0);
        lookup_i = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_taken",  32'(pred_taken_o), 32'd0);
        chk("arst_target", pred_target_o, 32'h414);
        chk("arst_ghr",    32'(pred_ghr_o), 32'd0);
        chk("arst_rasptr", 32'(pred_rasptr_o), 32'd0);
        idle();
        step();
        reset_n = 1'b1;
        step();
        pc_i = 32'h504;
        #1;
        chk("arst_btb_cleared", 32'(pred_taken_o), 32'd0);
        pc_i = 32'h200;
        #1;
        chk("arst_no_partial", 32'(pred_taken_o), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
